// File: rtl/energy_accept_ctrl.sv
// Sequencer for the J*sigma energy datapath. It fetches candidate spin vectors, launches one evaluation per
// candidate, samples the energy a fixed latency later, and keeps the current and best (energy, sigma) pairs.
module energy_accept_ctrl #(
    parameter int VECTOR_SIZE  = 256,
    parameter int ENERGY_WIDTH = 21,
    parameter int ITER_WIDTH   = 16,
    parameter int MM_LATENCY   = 260,
    parameter int ACCEPT_EQUAL = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run_start,
    input  logic                    abort,
    input  logic [ITER_WIDTH-1:0]   max_iter,
    input  logic [ENERGY_WIDTH-1:0] init_energy,
    input  logic [VECTOR_SIZE-1:0]  init_sigma,
    input  logic                    cand_valid,
    input  logic [VECTOR_SIZE-1:0]  cand_sigma,
    output logic                    cand_ready,
    output logic                    mm_start,
    output logic [VECTOR_SIZE-1:0]  mm_sigma,
    output logic [ENERGY_WIDTH-1:0] mm_energy_prev,
    input  logic [ENERGY_WIDTH-1:0] energy_in,
    output logic                    accepted,
    output logic [ENERGY_WIDTH-1:0] cur_energy,
    output logic [VECTOR_SIZE-1:0]  cur_sigma,
    output logic [ENERGY_WIDTH-1:0] best_energy,
    output logic [VECTOR_SIZE-1:0]  best_sigma,
    output logic [ITER_WIDTH-1:0]   iter_count,
    output logic                    busy,
    output logic                    done
);
    localparam int CNT_W = (MM_LATENCY > 1) ? $clog2(MM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_DECIDE, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [VECTOR_SIZE-1:0]  mm_sigma_q, mm_sigma_d;
    logic [ENERGY_WIDTH-1:0] cur_energy_q, cur_energy_d;
    logic [VECTOR_SIZE-1:0]  cur_sigma_q, cur_sigma_d;
    logic [ENERGY_WIDTH-1:0] best_energy_q, best_energy_d;
    logic [VECTOR_SIZE-1:0]  best_sigma_q, best_sigma_d;
    logic [ITER_WIDTH-1:0]   iter_q, iter_d;
    logic [ITER_WIDTH-1:0]   max_iter_q, max_iter_d;
    logic [ITER_WIDTH-1:0]   iter_inc;
    logic                    abort_hit;
    logic                    acc;
    logic                    beats_best;

    assign abort_hit = abort && (state_q != S_IDLE);
    assign iter_inc  = iter_q + 1'b1;

    always_comb begin
        acc = $signed(energy_in) < $signed(cur_energy_q);
        if ((ACCEPT_EQUAL != 0) && (energy_in == cur_energy_q)) begin
            acc = 1'b1;
        end
        beats_best = $signed(energy_in) < $signed(best_energy_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mm_sigma_q    <= '0;
            cur_energy_q  <= '0;
            cur_sigma_q   <= '0;
            best_energy_q <= '0;
            best_sigma_q  <= '0;
            iter_q        <= '0;
            max_iter_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mm_sigma_q    <= mm_sigma_d;
            cur_energy_q  <= cur_energy_d;
            cur_sigma_q   <= cur_sigma_d;
            best_energy_q <= best_energy_d;
            best_sigma_q  <= best_sigma_d;
            iter_q        <= iter_d;
            max_iter_q    <= max_iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (run_start) state_d = (max_iter == '0) ? S_DONE : S_FETCH;
            S_FETCH:        if (cand_valid) state_d = S_LAUNCH;
            S_LAUNCH:       state_d = S_WAIT;
            S_WAIT:         if (cnt_q == '0) state_d = S_DECIDE;
            S_DECIDE:       state_d = (iter_inc == max_iter_q) ? S_DONE : S_FETCH;
            default:        state_d = S_IDLE;
        endcase
        // Abort wins over every transition, including a DONE-state run_start.
        if (abort_hit) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        mm_sigma_d    = mm_sigma_q;
        cur_energy_d  = cur_energy_q;
        cur_sigma_d   = cur_sigma_q;
        best_energy_d = best_energy_q;
        best_sigma_d  = best_sigma_q;
        iter_d        = iter_q;
        max_iter_d    = max_iter_q;
        if (!abort_hit) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (run_start) begin
                        cur_energy_d  = init_energy;
                        cur_sigma_d   = init_sigma;
                        best_energy_d = init_energy;
                        best_sigma_d  = init_sigma;
                        iter_d        = '0;
                        max_iter_d    = max_iter;
                    end
                end
                S_FETCH:  if (cand_valid) mm_sigma_d = cand_sigma;
                S_LAUNCH: cnt_d = CNT_LOAD;
                S_WAIT:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                S_DECIDE: begin
                    if (acc) begin
                        cur_energy_d = energy_in;
                        cur_sigma_d  = mm_sigma_q;
                        if (beats_best) begin
                            best_energy_d = energy_in;
                            best_sigma_d  = mm_sigma_q;
                        end
                    end
                    iter_d = iter_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cand_ready = (state_q == S_FETCH);
        mm_start   = (state_q == S_LAUNCH) && !abort;
        accepted   = (state_q == S_DECIDE) && acc && !abort;
        busy       = (state_q == S_FETCH) || (state_q == S_LAUNCH) ||
                     (state_q == S_WAIT)  || (state_q == S_DECIDE);
        done       = (state_q == S_DONE);
    end

    assign mm_sigma       = mm_sigma_q;
    assign mm_energy_prev = cur_energy_q;
    assign cur_energy     = cur_energy_q;
    assign cur_sigma      = cur_sigma_q;
    assign best_energy    = best_energy_q;
    assign best_sigma     = best_sigma_q;
    assign iter_count     = iter_q;

endmodule
